// File: rtl/piece_queue_if.sv
// rtl/piece_queue_if.sv - spawn request/acknowledge bundle between the game FSM and the piece queue
interface piece_queue_if #(
    parameter int PIECE_W = 3
) ();
    logic               spawn_req;
    logic               spawn_ack;
    logic [PIECE_W-1:0] spawn_piece;

    modport master (
        output spawn_req,
        input  spawn_ack,
        input  spawn_piece
    );

    modport slave (
        input  spawn_req,
        output spawn_ack,
        output spawn_piece
    );
endinterface

// File: rtl/piece_queue.sv
// rtl/piece_queue.sv - next-piece preview FIFO with spawn req/ack handshake; optional PIECE_QUEUE_NO_REPEAT_EN
module piece_queue #(
    parameter int DEPTH   = 3,
    parameter int PIECE_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PIECE_W-1:0]         rand_piece,
    piece_queue_if.slave               spawn,
    output logic [DEPTH*PIECE_W-1:0]   preview,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ready
);
    localparam int                 CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]      FULL  = CW'(DEPTH);
    localparam logic [PIECE_W-1:0] EMPTY = {PIECE_W{1'b1}};

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        READY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PIECE_W-1:0] slots      [DEPTH];
    logic [PIECE_W-1:0] slots_next [DEPTH];
    logic [CW-1:0]      count_next;
    logic [CW-1:0]      post_pop;
    logic [PIECE_W-1:0] piece_reg;
    logic [PIECE_W-1:0] piece_next;
    logic               accept;
    logic               pop;
    logic               push;

`ifdef PIECE_QUEUE_NO_REPEAT_EN
    logic [PIECE_W-1:0] last_pushed;

    // Empty marker after reset never matches a real code, so the first push always passes
    assign accept = (rand_piece != EMPTY) && (rand_piece != last_pushed);

    // Track the most recent push so an immediate duplicate is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pushed <= EMPTY;
        end else if (push) begin
            last_pushed <= rand_piece;
        end
    end
`else
    assign accept = (rand_piece != EMPTY);
`endif

    // Next-state, pop/push decisions and the shifted/refilled queue image
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        push       = 1'b0;
        slots_next = slots;
        piece_next = piece_reg;

        case (state)
            FILL: begin
                push = accept && (count != FULL);
            end
            READY: begin
                if (spawn.spawn_req) begin
                    pop  = 1'b1;
                    push = accept;
                end
            end
            default: begin
            end
        endcase

        post_pop = pop ? (count - CW'(1)) : count;

        if (pop) begin
            piece_next = slots[0];
            for (int i = 0; i < DEPTH - 1; i++) begin
                slots_next[i] = slots[i + 1];
            end
            slots_next[DEPTH - 1] = EMPTY;
        end

        // A push lands in the first empty slot after any shift, so DEPTH=1 refills slot 0
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == post_pop) begin
                    slots_next[i] = rand_piece;
                end
            end
        end

        count_next = post_pop + CW'(push);

        case (state)
            FILL:    state_next = (count_next == FULL) ? READY : FILL;
            READY:   state_next = pop ? ACK : READY;
            ACK:     state_next = (count == FULL) ? READY : FILL;
            default: state_next = FILL;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Queue storage, occupancy and the last handed-out piece
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= EMPTY;
            end
            count     <= '0;
            piece_reg <= EMPTY;
        end else begin
            slots     <= slots_next;
            count     <= count_next;
            piece_reg <= piece_next;
        end
    end

    assign spawn.spawn_ack   = (state == ACK);
    assign spawn.spawn_piece = piece_reg;
    assign ready             = (count == FULL);

    for (genvar g = 0; g < DEPTH; g++) begin : g_preview
        assign preview[PIECE_W*g +: PIECE_W] = slots[g];
    end
endmodule
